ni_depacketizer: RTL and testbench
==================================

Name: ni_depacketizer

Overview:
Receive-side half of the network interface. Accepts flits from the router's local output port and checks the head flit's destination against the node ID. Strips the header and delivers payload words to the core as a framed stream with sop/eop/err/src sidebands. Buffers through a small payload FIFO and discards misaddressed packets.

Parameters:
DATA_W, 32, payload width; flit width is DATA_W+2
ID_W, 8, node ID width
LEN_W, 8, head length field width (number of data flits)
FIFO_DEPTH, 8, payload FIFO entries (power of 2, >=2)
CNT_W, 16, drop counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low (0 = reset)
my_id  in  ID_W  this node's ID, static
flit_in  in  DATA_W+2  [DATA_W+1:DATA_W] type: 01 head, 00 body, 10 tail, 11 reserved; [DATA_W-1:0] payload
flit_in_valid  in  1  flit present
flit_in_ready  out  1  flit accepted when valid&ready
pkt_out_data  out  DATA_W  payload word to core
pkt_out_src  out  ID_W  source ID of the packet
pkt_out_sop  out  1  first word of packet
pkt_out_eop  out  1  last word of packet
pkt_out_err  out  1  packet malformed; valid only with eop
pkt_out_valid  out  1  word present
pkt_out_ready  in  1  core accepts when valid&ready
drop_cnt  out  CNT_W  packets dropped (saturating)
proto_err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Head payload: dst = [DATA_W-1 -: ID_W]; src = next ID_W bits; len = next LEN_W bits. Requires 2*ID_W+LEN_W <= DATA_W.
- Reset (reset=0, async): state IDLE; FIFO empty; all outputs 0; drop_cnt=0.
- FSM states: IDLE, RECV, DROP, CLOSE.
- IDLE: flit_in_ready=1.
  - Head with dst==my_id and len!=0: latch src and len, set cnt=0, go to RECV.
  - Head with dst!=my_id: drop_cnt+=1, go to DROP.
  - Head with len==0: proto_err pulse, stay in IDLE.
  - Non-head flit: consume and discard, proto_err pulse, stay in IDLE.
- RECV: flit_in_ready = !fifo_full. The full check ignores a same-cycle pop.
  - Each body/tail flit pushes entry {data, src, sop=(cnt==0), eop, err} and increments cnt.
  - eop = (type==tail) | (cnt+1==len).
  - err = eop & !((type==tail) & (cnt+1==len)). A mismatch also pulses proto_err.
  - On eop, go to IDLE.
  - Head flit in RECV: do not consume it (flit_in_ready=0), pulse proto_err, go to CLOSE.
  - Reserved type (11): treat as body and pulse proto_err.
- CLOSE: flit_in_ready=0.
  - When the FIFO is not full, push {data=0, sop=0, eop=1, err=1}, then go to IDLE.
  - The pending head is consumed afterwards from IDLE.
- DROP: flit_in_ready=1. Discard flits until a tail is accepted, then go to IDLE.
  - A head arriving in DROP is discarded and pulses proto_err.
- Latency: a flit accepted in cycle N is visible on pkt_out_* in cycle N+1 at the earliest. The registered FIFO has no bypass.
- FIFO: pointers wrap modulo FIFO_DEPTH. Full and empty use an extra pointer bit. Push and pop in the same cycle are allowed when not full and not empty.
- pkt_out_valid = !fifo_empty. Output fields hold stable while valid&!ready.
- drop_cnt saturates at all-ones.
- proto_err is registered: it pulses one cycle after the offending acceptance.

Test Plan:
- my_id=0x05. Send head(dst=05, src=02, len=3), body 0xA, body 0xB, tail 0xC; pkt_out_ready=1 -> three words out from the cycle after the first body. Word 0xA has sop=1; word 0xC has eop=1, err=0, src=02.
- Send head(dst=07, len=2), body, tail -> no pkt_out_valid; drop_cnt=1; flit_in_ready stays 1 throughout.
- FIFO_DEPTH=8, pkt_out_ready=0, head(len=10) plus 10 data flits -> flit_in_ready drops after 8 data accepts. Raise ready -> all 10 words delivered in order; eop on the 10th.
- Head(len=4), body, tail -> tail word has eop=1, err=1; proto_err pulses once.
- Head(len=3), body, then a new head -> CLOSE pushes a zero word with eop=1, err=1. The new head is then accepted and its packet is delivered normally.
- A stray body in IDLE -> proto_err pulses and no output. Assert reset mid-RECV -> flit_in_ready=0, pkt_out_valid=0, drop_cnt=0 immediately (async). A fresh packet after release is delivered correctly.

Source files
------------

// File: rtl/ni_depacketizer.sv
`default_nettype none
// ============================================================================
// Module   : ni_depacketizer
// Purpose  : Receive half of the network interface. Parses head flits from
//            the router's local port and accepts packets addressed to my_id.
//            It strips the header and delivers the payload words to the core
//            through a registered FIFO, as a framed stream with sop/eop/err
//            and source-ID sidebands. Misaddressed packets are discarded and
//            counted.
// Ports    : clk, reset (async, active-low)
//            my_id                          - this node's ID (static)
//            flit_in/_valid/_ready          - flit input; [DATA_W+1:DATA_W] is
//                                             the type (01 head, 00 body,
//                                             10 tail, 11 reserved)
//            pkt_out_data/_src/_sop/_eop/_err/_valid/_ready - payload stream
//            drop_cnt                       - saturating dropped-packet count
//            proto_err                      - 1-cycle protocol-violation pulse
// Revision : 1.0 - initial release
// ============================================================================
module ni_depacketizer #(
  parameter int DATA_W     = 32,
  parameter int ID_W       = 8,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 8,   // power of 2, >= 2
  parameter int CNT_W      = 16   // header fields need 2*ID_W+LEN_W <= DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   my_id,
  input  logic [DATA_W+1:0] flit_in,
  input  logic              flit_in_valid,
  output logic              flit_in_ready,
  output logic [DATA_W-1:0] pkt_out_data,
  output logic [ID_W-1:0]   pkt_out_src,
  output logic              pkt_out_sop,
  output logic              pkt_out_eop,
  output logic              pkt_out_err,
  output logic              pkt_out_valid,
  input  logic              pkt_out_ready,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              proto_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + ID_W + 3;  // {data, src, sop, eop, err}
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_RSV  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2, CLOSE = 2'd3} state_t;
  state_t state, state_nxt;

  logic [1:0]        ftype;
  logic [ID_W-1:0]   hd_dst, hd_src;
  logic [LEN_W-1:0]  hd_len;
  logic [ID_W-1:0]   src_q;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic [LEN_W:0]    cnt_p1;
  logic              len_hit, last_w, err_w;
  logic              ready_w, push, pop, full, empty;
  logic              latch_hdr, cnt_inc, drop_inc, perr_nxt;
  logic [EW-1:0]     push_entry, rd_entry;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;

  assign ftype  = flit_in[DATA_W+1:DATA_W];
  assign hd_dst = flit_in[DATA_W-1 -: ID_W];
  assign hd_src = flit_in[DATA_W-1-ID_W -: ID_W];
  assign hd_len = flit_in[DATA_W-1-2*ID_W -: LEN_W];

  // One bit wider than cnt so the compare cannot wrap.
  assign cnt_p1  = {1'b0, cnt_q} + (LEN_W+1)'(1);
  assign len_hit = (cnt_p1 == {1'b0, len_q});
  assign last_w  = (ftype == T_TAIL) | len_hit;
  // Malformed: the packet ends on only one of the two criteria.
  assign err_w   = last_w & !((ftype == T_TAIL) & len_hit);

  // The full flag ignores a same-cycle pop, so the input never depends on
  // the core's ready.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign pop   = pkt_out_ready & !empty;

  always_comb begin
    state_nxt  = state;
    ready_w    = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    latch_hdr  = 1'b0;
    cnt_inc    = 1'b0;
    drop_inc   = 1'b0;
    perr_nxt   = 1'b0;
    case (state)
      IDLE: begin
        ready_w = 1'b1;
        if (flit_in_valid) begin
          if (ftype != T_HEAD) begin
            perr_nxt = 1'b1;
          end else if (hd_dst != my_id) begin
            drop_inc  = 1'b1;
            state_nxt = DROP;
          end else if (hd_len == '0) begin
            perr_nxt = 1'b1;
          end else begin
            latch_hdr = 1'b1;
            state_nxt = RECV;
          end
        end
      end
      RECV: begin
        if (flit_in_valid && ftype == T_HEAD) begin
          // Leave the new head pending; close the truncated packet first.
          perr_nxt  = 1'b1;
          state_nxt = CLOSE;
        end else begin
          ready_w = !full;
          if (flit_in_valid && !full) begin
            push       = 1'b1;
            cnt_inc    = 1'b1;
            push_entry = {flit_in[DATA_W-1:0], src_q, (cnt_q == '0), last_w, err_w};
            perr_nxt   = err_w | (ftype == T_RSV);
            if (last_w) state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        ready_w = 1'b1;
        if (flit_in_valid) begin
          if (ftype == T_HEAD) perr_nxt = 1'b1;
          if (ftype == T_TAIL) state_nxt = IDLE;
        end
      end
      CLOSE: begin
        if (!full) begin
          push       = 1'b1;
          push_entry = {{DATA_W{1'b0}}, src_q, 1'b0, 1'b1, 1'b1};
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is forced low while reset is held, not only after the next edge.
  assign flit_in_ready = reset & ready_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      drop_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= perr_nxt;
      if (latch_hdr) begin
        src_q <= hd_src;
        len_q <= hd_len;
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: nothing reads it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  assign rd_entry      = mem[rd_ptr[AW-1:0]];
  assign pkt_out_valid = !empty;
  assign {pkt_out_data, pkt_out_src, pkt_out_sop, pkt_out_eop, pkt_out_err} =
         empty ? '0 : rd_entry;

endmodule
`default_nettype wire

// File: tb/tb_ni_depacketizer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ni_depacketizer
// Purpose  : Self-checking bench for ni_depacketizer. A packet-level model
//            predicts the payload stream, drop count and proto_err pulses.
//            Directed scenarios are followed by a randomized flit stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ni_depacketizer;
  localparam int DATA_W = 32, ID_W = 8, LEN_W = 8, FIFO_DEPTH = 8, CNT_W = 4;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_RSV = 2'b11;
  localparam logic [ID_W-1:0] MY_ID = 8'h05;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  src;
    logic        sop;
    logic        eop;
    logic        err;
  } word_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [ID_W-1:0]   my_id;
  logic [DATA_W+1:0] flit_in;
  logic              flit_in_valid, flit_in_ready;
  logic [DATA_W-1:0] pkt_out_data;
  logic [ID_W-1:0]   pkt_out_src;
  logic              pkt_out_sop, pkt_out_eop, pkt_out_err, pkt_out_valid, pkt_out_ready;
  logic [CNT_W-1:0]  drop_cnt;
  logic              proto_err;

  ni_depacketizer #(.DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W),
                    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .my_id(my_id),
    .flit_in(flit_in), .flit_in_valid(flit_in_valid), .flit_in_ready(flit_in_ready),
    .pkt_out_data(pkt_out_data), .pkt_out_src(pkt_out_src), .pkt_out_sop(pkt_out_sop),
    .pkt_out_eop(pkt_out_eop), .pkt_out_err(pkt_out_err), .pkt_out_valid(pkt_out_valid),
    .pkt_out_ready(pkt_out_ready), .drop_cnt(drop_cnt), .proto_err(proto_err));

  always #5 clk = ~clk;

  int    n_vec = 0, n_err = 0, cyc = 0;
  word_t exp_q[$];
  word_t log_q[$];
  int    log_cyc[$];
  int    perr_seen = 0, exp_perr = 0, exp_drop = 0, last_acc = 0;
  bit    in_pkt = 0, dropping = 0, rnd_rdy = 0;
  logic [7:0] cur_src;
  int    cur_len, got;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W+1:0] mk_head(input logic [7:0] dst, input logic [7:0] src,
                                                input logic [7:0] len);
    return {T_HEAD, dst, src, len, 8'h00};
  endfunction

  function automatic logic [DATA_W+1:0] mk_data(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  // ---------------- packet-level reference model ----------------
  function automatic void model_reset();
    exp_q.delete();
    in_pkt = 0; dropping = 0; exp_drop = 0; exp_perr = 0; perr_seen = 0;
  endfunction

  // A head that shows up inside an open packet truncates it with an error word.
  function automatic void model_pre(input logic [DATA_W+1:0] f);
    if (in_pkt && f[33:32] == T_HEAD) begin
      exp_q.push_back({32'd0, cur_src, 1'b0, 1'b1, 1'b1});
      exp_perr++;
      in_pkt = 0;
    end
  endfunction

  function automatic void model_accept(input logic [DATA_W+1:0] f);
    logic [1:0] t = f[33:32];
    bit last, bad;
    if (dropping) begin
      if (t == T_HEAD) exp_perr++;
      if (t == T_TAIL) dropping = 0;
    end else if (!in_pkt) begin
      if (t != T_HEAD) exp_perr++;
      else if (f[31:24] != MY_ID) begin
        if (exp_drop < (1 << CNT_W) - 1) exp_drop++;
        dropping = 1;
      end else if (f[15:8] == 8'd0) exp_perr++;
      else begin
        in_pkt = 1; cur_src = f[23:16]; cur_len = int'(f[15:8]); got = 0;
      end
    end else begin
      got++;
      last = (t == T_TAIL) || (got == cur_len);
      bad  = last && !((t == T_TAIL) && (got == cur_len));
      exp_q.push_back({f[31:0], cur_src, (got == 1), last, bad});
      if (bad || t == T_RSV) exp_perr++;
      if (last) in_pkt = 0;
    end
  endfunction

  // ---------------- output compare process ----------------
  word_t cur, w_exp, hold_word;
  bit    hold_pend = 0;
  always @(negedge clk) begin
    if (reset) begin
      cur = {pkt_out_data, pkt_out_src, pkt_out_sop, pkt_out_eop, pkt_out_err};
      if (proto_err) perr_seen++;
      if (hold_pend) begin
        chk("hold_valid", 64'(pkt_out_valid), 64'd1);
        chk("hold_word", 64'(cur), 64'(hold_word));
      end
      hold_pend = pkt_out_valid && !pkt_out_ready;
      hold_word = cur;
      if (pkt_out_valid && pkt_out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_word: got %0h, nothing expected", cur);
        end else begin
          w_exp = exp_q.pop_front();
          chk("out_word", 64'(cur), 64'(w_exp));
        end
        log_q.push_back(cur);
        log_cyc.push_back(cyc);
      end
    end else begin
      hold_pend = 0;
    end
  end

  // Random core backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) pkt_out_ready = ($urandom % 4) != 0;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_flit(input logic [DATA_W+1:0] f, input int limit, output bit ok, output int waits);
    model_pre(f);
    flit_in = f; flit_in_valid = 1'b1; ok = 0; waits = 0;
    while (!ok && waits < limit) begin
      @(negedge clk); waits++;
      if (flit_in_ready) begin
        ok = 1; last_acc = cyc; model_accept(f);
      end
      @(posedge clk); #1;
    end
    flit_in_valid = 1'b0; flit_in = '0;
  endtask

  task automatic send(input logic [DATA_W+1:0] f);
    bit ok; int w;
    send_flit(f, 200, ok, w);
    chk("accept", 64'(ok), 64'd1);
  endtask

  task automatic send1(input logic [DATA_W+1:0] f);  // must be taken at once
    bit ok; int w;
    send_flit(f, 200, ok, w);
    chk("ready_immediate", 64'(w), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || pkt_out_valid) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_expected_left", 64'(exp_q.size()), 64'd0);
    chk("drain_valid_low", 64'(pkt_out_valid), 64'd0);
  endtask

  int base, p0, ws;
  bit okb;

  initial begin
    reset = 1'b0; my_id = MY_ID; flit_in = '0; flit_in_valid = 1'b0; pkt_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(flit_in_ready), 64'd0);
    chk("rst_valid", 64'(pkt_out_valid), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // 1: good packet, latency and framing
    pkt_out_ready = 1'b1; base = log_q.size();
    send1(mk_head(MY_ID, 8'h02, 8'd3));
    send1(mk_data(T_BODY, 32'hA)); p0 = last_acc;
    send1(mk_data(T_BODY, 32'hB));
    send1(mk_data(T_TAIL, 32'hC));
    drain();
    chk("t1_count", 64'(log_q.size() - base), 64'd3);
    chk("t1_latency", 64'(log_cyc[base]), 64'(p0 + 1));
    chk("t1_first", 64'(log_q[base]), {21'd0, 32'hA, 8'h02, 1'b1, 1'b0, 1'b0});
    chk("t1_last", 64'(log_q[base+2]), {21'd0, 32'hC, 8'h02, 1'b0, 1'b1, 1'b0});

    // 2: misaddressed packet is dropped
    base = log_q.size();
    send1(mk_head(8'h07, 8'h02, 8'd2));
    send1(mk_data(T_BODY, 32'h1));
    send1(mk_data(T_TAIL, 32'h2));
    drain();
    chk("t2_no_output", 64'(log_q.size() - base), 64'd0);
    chk("t2_drop_cnt", 64'(drop_cnt), 64'd1);

    // 3: FIFO fill with core stalled
    pkt_out_ready = 1'b0; base = log_q.size();
    send1(mk_head(MY_ID, 8'h06, 8'd10));
    for (int i = 1; i <= 8; i++) send1(mk_data(T_BODY, 32'(i)));
    send_flit(mk_data(T_BODY, 32'd9), 4, okb, ws);
    chk("t3_full_stall", 64'(okb), 64'd0);
    pkt_out_ready = 1'b1;
    send(mk_data(T_BODY, 32'd9));
    send(mk_data(T_TAIL, 32'd10));
    drain();
    chk("t3_count", 64'(log_q.size() - base), 64'd10);
    for (int i = 0; i < 9; i++)
      chk("t3_word", 64'(log_q[base+i]), {21'd0, 32'(i + 1), 8'h06, (i == 0), 1'b0, 1'b0});
    chk("t3_last", 64'(log_q[base+9]), {21'd0, 32'd10, 8'h06, 1'b0, 1'b1, 1'b0});

    // 4: early tail
    base = log_q.size(); p0 = perr_seen;
    send1(mk_head(MY_ID, 8'h02, 8'd4));
    send1(mk_data(T_BODY, 32'h31));
    send1(mk_data(T_TAIL, 32'h32));
    drain();
    chk("t4_perr", 64'(perr_seen - p0), 64'd1);
    chk("t4_tail", 64'(log_q[base+1]), {21'd0, 32'h32, 8'h02, 1'b0, 1'b1, 1'b1});

    // 5: head inside an open packet
    base = log_q.size(); p0 = perr_seen;
    send(mk_head(MY_ID, 8'h03, 8'd3));
    send(mk_data(T_BODY, 32'h11));
    send(mk_head(MY_ID, 8'h04, 8'd1));
    send(mk_data(T_TAIL, 32'h22));
    drain();
    chk("t5_count", 64'(log_q.size() - base), 64'd3);
    chk("t5_close", 64'(log_q[base+1]), {21'd0, 32'h0, 8'h03, 1'b0, 1'b1, 1'b1});
    chk("t5_next", 64'(log_q[base+2]), {21'd0, 32'h22, 8'h04, 1'b1, 1'b1, 1'b0});
    chk("t5_perr", 64'(perr_seen - p0), 64'd1);

    // 6: stray body in IDLE
    base = log_q.size(); p0 = perr_seen;
    send1(mk_data(T_BODY, 32'h77));
    drain();
    chk("t6_perr", 64'(perr_seen - p0), 64'd1);
    chk("t6_no_output", 64'(log_q.size() - base), 64'd0);

    // 7: async reset in the middle of a packet
    pkt_out_ready = 1'b0;
    send(mk_head(MY_ID, 8'h09, 8'd5));
    send(mk_data(T_BODY, 32'h1));
    send(mk_data(T_BODY, 32'h2));
    @(posedge clk); #2;
    reset = 1'b0; flit_in = mk_data(T_BODY, 32'h3); flit_in_valid = 1'b1;
    #1;
    chk("arst_ready", 64'(flit_in_ready), 64'd0);
    chk("arst_valid", 64'(pkt_out_valid), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    model_reset();
    flit_in_valid = 1'b0; flit_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    pkt_out_ready = 1'b1; base = log_q.size();
    send1(mk_head(MY_ID, 8'h0A, 8'd2));
    send1(mk_data(T_BODY, 32'h55));
    send1(mk_data(T_TAIL, 32'h66));
    drain();
    chk("t7_count", 64'(log_q.size() - base), 64'd2);
    chk("t7_first", 64'(log_q[base]), {21'd0, 32'h55, 8'h0A, 1'b1, 1'b0, 1'b0});
    chk("t7_last", 64'(log_q[base+1]), {21'd0, 32'h66, 8'h0A, 1'b0, 1'b1, 1'b0});
    chk("t7_drop", 64'(drop_cnt), 64'd0);

    // 8: randomized flit stream with random backpressure
    rnd_rdy = 1;
    for (int p = 0; p < 150; p++) begin
      logic [7:0] dst, src, len;
      int k;
      bit notail;
      logic [1:0] t;
      dst = (($urandom % 4) == 0) ? (MY_ID ^ 8'($urandom_range(1, 255))) : MY_ID;
      src = 8'($urandom);
      len = 8'($urandom_range(0, 6));
      send(mk_head(dst, src, len));
      case ($urandom % 6)
        0:       k = int'(len) + 1;
        1:       k = (len > 0) ? int'(len) - 1 : 0;
        default: k = int'(len);
      endcase
      notail = ($urandom % 8) == 0;
      for (int j = 1; j <= k; j++) begin
        t = (j == k && !notail) ? T_TAIL : ((($urandom % 10) == 0) ? T_RSV : T_BODY);
        send(mk_data(t, 32'($urandom)));
      end
    end
    drain();
    chk("final_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("final_perr_count", 64'(perr_seen), 64'(exp_perr));
    rnd_rdy = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
